cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
- Upstream feeder of the common data bus register.
- Collects completed results (16-bit value plus 3-bit reservation-station tag) from several functional units.
- Buffers each unit's results in a small per-source FIFO.
- Each cycle, grants at most one buffered result in round-robin order. Drives the CDB's data/tag/strobe inputs as registered outputs.

Parameters:
- NUM_SRC, 4, number of functional-unit result sources (add, add, mul, load).
- DATA_W, 16, result data width.
- TAG_W, 3, reservation-station name width.
- DEPTH, 2, entries per source FIFO (power of 2, ≥2).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- src_valid  in  NUM_SRC  per-source result-present strobe.
- src_data  in  NUM_SRC*DATA_W  packed results; source i at [i*DATA_W +: DATA_W].
- src_tag  in  NUM_SRC*TAG_W  packed RS names; source i at [i*TAG_W +: TAG_W].
- src_ready  out  NUM_SRC  source i FIFO not full.
- cdb_data  out  DATA_W  result to CDB input.
- cdb_RS_Name  out  TAG_W  RS name to CDB.
- cdb_sinal  out  1  one-cycle write strobe to CDB.
- grant  out  NUM_SRC  one-hot: which source owns the current cdb_sinal beat.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - All FIFOs empty; rr_ptr=0.
  - cdb_data=0, cdb_RS_Name=0, cdb_sinal=0, grant=0.
  - src_ready=all ones once reset is low.
- Push:
  - At a clock edge with src_valid[i]&&src_ready[i], {src_data,src_tag} of source i is written at that FIFO's tail.
  - src_valid while !src_ready is ignored; the source must hold its result.
- src_ready[i] = (count_i < DEPTH). It is combinational from state only, with no pop lookahead, so a full FIFO refuses a push even in a cycle it pops.
- Arbitration, combinational over state at cycle start:
  - Scan sources rr_ptr, rr_ptr+1, … mod NUM_SRC.
  - The first with a non-empty FIFO wins.
  - The winner's head pops at the edge.
- Registered outputs, at that same edge:
  - cdb_data/cdb_RS_Name load the head entry.
  - cdb_sinal=1; grant=one-hot(winner).
  - rr_ptr=(winner+1) mod NUM_SRC.
- No winner: cdb_sinal=0, grant=0, cdb_data/cdb_RS_Name hold their last values, rr_ptr unchanged.
- Latency: a result accepted at edge E0 is eligible at E1. If uncontended, cdb_sinal is high for the cycle after E1. There is no same-cycle bypass.
- Throughput: exactly one result per cycle whenever any FIFO is non-empty.
- Simultaneous push and pop on the same non-full FIFO: both occur; count unchanged; order preserved.
- FIFO pointers wrap mod DEPTH; count ranges 0..DEPTH.
- Fairness: with all sources backlogged, grants rotate 0,1,2,3,0,… No source waits more than NUM_SRC-1 beats once it reaches its FIFO head.
- Reset mid-operation discards all buffered entries immediately. Strobe and grant drop asynchronously.
- Tag values pass through unmodified, including 0.

Decomposition:
- Shared package holds:
  - DATA_W and TAG_W constants, also used by CDB and reservation stations.
  - The result-entry struct {data, tag}.
- Natural sub-module: result_fifo.
  - Parameterized DEPTH/width; async active-high reset.
  - Ports: push, pop, din, dout(head), empty, full.
  - Instantiated NUM_SRC times.
- The round-robin pick and output registers live in cdb_arbiter.

Test Plan:
- Single source: reset, push src 2 {0x1234, tag 5} at edge E0 → after E1: cdb_sinal=1, cdb_data=0x1234, cdb_RS_Name=5, grant=0100. Next cycle cdb_sinal=0 and data holds 0x1234.
- Contention: all four push in the same edge (data 0xA000+i, tag i+1), rr_ptr=0 → four consecutive beats from sources 0,1,2,3. rr_ptr ends at 0 and cdb_sinal drops on the fifth cycle.
- Backpressure: source 1 pushes 3 times while source 0 is kept backlogged.
  - src_ready[1]=0 after 2 pushes. The third push is ignored until source 1 is granted.
  - Order delivered is the first two values only.
  - A re-push after src_ready returns to 1 is accepted.
- Round-robin wrap: rr_ptr=3 with sources 0 and 3 pending → source 3 granted first, then 0; rr_ptr=1 afterwards.
- Push+pop same FIFO: source 0 sends a continuous stream of 6 values while it is the only requester → 6 beats back-to-back in push order, src_ready[0] stays 1.
- Reset mid-operation: FIFOs holding 5 entries, assert reset mid-cycle → outputs and grant go 0 immediately. After release, no stale beats appear and all src_ready=1.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common-data-bus result path.
// The widths here are shared with the CDB register and the reservation stations.
package cdb_arbiter_pkg;

    localparam int DATA_W  = 16;
    localparam int TAG_W   = 3;

    // One completed result: value plus the name of the reservation station that produced it
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } cdb_entry_t;

    localparam int ENTRY_W = $bits(cdb_entry_t);

    // Builds an entry from separate data and tag fields
    function automatic cdb_entry_t make_entry(input logic [DATA_W-1:0] d,
                                              input logic [TAG_W-1:0]  t);
        cdb_entry_t e;
        e.data = d;
        e.tag  = t;
        return e;
    endfunction

endpackage

// File: rtl/cdb_arbiter_result_fifo.sv
// Small synchronous FIFO that buffers one functional unit's results.
// The head entry is always visible on dout; dout is only meaningful when !empty.
// Pushes while full and pops while empty are dropped internally.
module result_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Storage array: written at the tail, never cleared (occupancy tracked by count)
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy control; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Collects results from several functional units, buffers them per source,
// and hands at most one per cycle to the common data bus in round-robin order.
// Outputs are registered; a result pushed at one edge can drive the bus one edge later.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DEPTH   = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
    output logic [NUM_SRC-1:0]        src_ready,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [TAG_W-1:0]          cdb_RS_Name,
    output logic                      cdb_sinal,
    output logic [NUM_SRC-1:0]        grant
);

    localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    cdb_entry_t         in_entry   [NUM_SRC];
    cdb_entry_t         head_entry [NUM_SRC];
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [NUM_SRC-1:0] empty;
    logic [NUM_SRC-1:0] full;
    logic [SEL_W-1:0]   rr_ptr;
    logic [SEL_W-1:0]   winner;
    logic               found;

    // Source index k places after base, modulo NUM_SRC
    function automatic logic [SEL_W-1:0] rr_slot(input logic [SEL_W-1:0] base, input int k);
        return SEL_W'((int'(base) + k) % NUM_SRC);
    endfunction

    // Pointer position just after the winner, modulo NUM_SRC
    function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] w);
        return (int'(w) == NUM_SRC - 1) ? '0 : w + SEL_W'(1);
    endfunction

    // A full FIFO refuses pushes even in a cycle it pops, so ready depends on state only
    assign src_ready = ~full;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign in_entry[i] = make_entry(src_data[i*DATA_W +: DATA_W], src_tag[i*TAG_W +: TAG_W]);
        assign push[i]     = src_valid[i] & ~full[i];
        assign pop[i]      = found && (winner == SEL_W'(i));

        result_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clock (clock),
            .reset (reset),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   (in_entry[i]),
            .dout  (head_entry[i]),
            .empty (empty[i]),
            .full  (full[i])
        );
    end

    // Round-robin pick: first non-empty FIFO scanning upward from rr_ptr
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!found && !empty[rr_slot(rr_ptr, k)]) begin
                found  = 1'b1;
                winner = rr_slot(rr_ptr, k);
            end
        end
    end

    // Bus-facing registers: load the winner's head, strobe for one cycle, advance the pointer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cdb_data    <= '0;
            cdb_RS_Name <= '0;
            cdb_sinal   <= 1'b0;
            grant       <= '0;
            rr_ptr      <= '0;
        end else if (found) begin
            cdb_data    <= head_entry[winner].data;
            cdb_RS_Name <= head_entry[winner].tag;
            cdb_sinal   <= 1'b1;
            grant       <= NUM_SRC'(1) << winner;
            rr_ptr      <= rr_next(winner);
        end else begin
            cdb_sinal   <= 1'b0;
            grant       <= '0;
        end
    end

endmodule
